// File: rtl/pipeline_stall_ctrl.sv
// pipeline_stall_ctrl
//   Central stall/flush sequencer for the 5-stage MIPS pipeline. It merges
//   load-use hazards, taken branches/jumps and multi-cycle data-memory
//   accesses into one prioritised set of enables and bubble controls:
//   memory freeze > load-use bubble > branch flush > normal advance.
//   It owns the memory-wait watchdog and the wrong-path flush sequencing.
//
// Parameters
//   FLUSH_DEPTH  IF/ID flush cycles per taken branch/jump (1..3)
//   MEM_TIMEOUT  cycle budget of one memory wait before abort (2..255)
//
// Ports
//   clk_i, rst_i           clock, synchronous active-low reset
//   IDEX_MemRead_i         ID/EX holds a load
//   IDEX_RegisterRt_i      load destination register
//   IFID_RegisterRs/Rt_i   source registers of the instruction in ID
//   Branch_i               taken branch/jump resolved this cycle
//   mem_req_i, mem_ack_i   data-memory access present / completing
//   PCWrite_o, IFIDWrite_o PC and IF/ID load enables
//   IFIDFlush_o            IF/ID cleared to NOP
//   IDEXBubble_o           ID/EX loads a control-zero bubble
//   EXMEMStall_o           hold EX/MEM and MEM/WB
//   mem_err_o              sticky memory-timeout flag
//
// Optional feature (macro STALL_PERF_CNT_EN)
//   stall_cycles_o         saturating count of cycles with PCWrite_o low
//   flush_cycles_o         saturating count of cycles with IFIDFlush_o high
module pipeline_stall_ctrl #(
    parameter int unsigned FLUSH_DEPTH = 1,
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        IDEX_MemRead_i,
    input  logic [4:0]  IDEX_RegisterRt_i,
    input  logic [4:0]  IFID_RegisterRs_i,
    input  logic [4:0]  IFID_RegisterRt_i,
    input  logic        Branch_i,
    input  logic        mem_req_i,
    input  logic        mem_ack_i,
    output logic        PCWrite_o,
    output logic        IFIDWrite_o,
    output logic        IFIDFlush_o,
    output logic        IDEXBubble_o,
    output logic        EXMEMStall_o,
`ifdef STALL_PERF_CNT_EN
    output logic [31:0] stall_cycles_o,
    output logic [31:0] flush_cycles_o,
`endif
    output logic        mem_err_o
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        FLUSH    = 2'd2
    } state_t;

    localparam logic [8:0] TMO_LIMIT = 9'(MEM_TIMEOUT);

    state_t     state_q, state_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic [1:0] flush_rem_q, flush_rem_d;
    logic       mem_err_q, mem_err_d;

    logic load_use, miss, hold_req, timeout, freeze;
    logic pcw, ifw, flush, bubble, stall;

    assign load_use = IDEX_MemRead_i && (IDEX_RegisterRt_i != 5'd0) &&
                      ((IDEX_RegisterRt_i == IFID_RegisterRs_i) ||
                       (IDEX_RegisterRt_i == IFID_RegisterRt_i));
    assign miss     = mem_req_i && !mem_ack_i;

    // Once waiting, only the ack ends the wait; elsewhere a fresh miss starts one.
    assign hold_req = (state_q == MEM_WAIT) ? !mem_ack_i : miss;
    // The cycle whose increment would reach the budget aborts instead of stalling,
    // so at most MEM_TIMEOUT-1 cycles are ever frozen.
    assign timeout  = hold_req && (({1'b0, wait_cnt_q} + 9'd1) >= TMO_LIMIT);
    assign freeze   = hold_req && !timeout;

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        flush_rem_d = flush_rem_q;
        mem_err_d   = mem_err_q;
        pcw         = 1'b0;
        ifw         = 1'b0;
        flush       = 1'b0;
        bubble      = 1'b0;
        stall       = 1'b0;

        if (freeze) begin
            // Freeze keeps the current state (and any remaining flush count).
            stall      = 1'b1;
            wait_cnt_d = wait_cnt_q + 8'd1;
            if (state_q == RUN) begin
                state_d = MEM_WAIT;
            end
        end else begin
            wait_cnt_d = '0;
            if (timeout) begin
                mem_err_d = 1'b1;
            end
            if (state_q == FLUSH) begin
                pcw         = 1'b1;
                flush       = 1'b1;
                flush_rem_d = flush_rem_q - 2'd1;
                if (flush_rem_q == 2'd1) begin
                    state_d = RUN;
                end
            end else begin
                state_d = RUN;
                if (load_use) begin
                    bubble = 1'b1;
                end else if (Branch_i) begin
                    pcw   = 1'b1;
                    flush = 1'b1;
                    if (FLUSH_DEPTH > 1) begin
                        state_d     = FLUSH;
                        flush_rem_d = 2'(FLUSH_DEPTH - 1);
                    end
                end else begin
                    pcw = 1'b1;
                    ifw = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q     <= RUN;
            wait_cnt_q  <= '0;
            flush_rem_q <= '0;
            mem_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            flush_rem_q <= flush_rem_d;
            mem_err_q   <= mem_err_d;
        end
    end

    // While in reset the pipeline is held with NOPs injected into IF/ID and ID/EX.
    assign PCWrite_o    = rst_i && pcw;
    assign IFIDWrite_o  = rst_i && ifw;
    assign IFIDFlush_o  = !rst_i || flush;
    assign IDEXBubble_o = !rst_i || bubble;
    assign EXMEMStall_o = rst_i && stall;
    // The abort cycle already reports the error.
    assign mem_err_o    = rst_i && (mem_err_q || timeout);

`ifdef STALL_PERF_CNT_EN
    logic [31:0] stall_cnt_q, flush_cnt_q;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (!pcw && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (flush && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + 32'd1;
            end
        end
    end

    assign stall_cycles_o = stall_cnt_q;
    assign flush_cycles_o = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
module tb_pipeline_stall_ctrl;

    localparam int unsigned FD = 2;
    localparam int unsigned MT = 16;

    // {PCWrite, IFIDWrite, IFIDFlush, IDEXBubble, EXMEMStall}
    localparam logic [4:0] O_RST = 5'b00110;
    localparam logic [4:0] O_RUN = 5'b11000;
    localparam logic [4:0] O_BUB = 5'b00010;
    localparam logic [4:0] O_FLU = 5'b10100;
    localparam logic [4:0] O_FRZ = 5'b00001;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       memread, branch, req, ack;
    logic [4:0] idex_rt, ifid_rs, ifid_rt;
    logic       pcw, ifw, flush, bub, stall, mem_err;
`ifdef STALL_PERF_CNT_EN
    logic [31:0] stall_cycles, flush_cycles;
`endif
    logic [4:0] outs;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    pipeline_stall_ctrl #(.FLUSH_DEPTH(FD), .MEM_TIMEOUT(MT)) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .IDEX_MemRead_i    (memread),
        .IDEX_RegisterRt_i (idex_rt),
        .IFID_RegisterRs_i (ifid_rs),
        .IFID_RegisterRt_i (ifid_rt),
        .Branch_i          (branch),
        .mem_req_i         (req),
        .mem_ack_i         (ack),
        .PCWrite_o         (pcw),
        .IFIDWrite_o       (ifw),
        .IFIDFlush_o       (flush),
        .IDEXBubble_o      (bub),
        .EXMEMStall_o      (stall),
`ifdef STALL_PERF_CNT_EN
        .stall_cycles_o    (stall_cycles),
        .flush_cycles_o    (flush_cycles),
`endif
        .mem_err_o         (mem_err)
    );

    assign outs = {pcw, ifw, flush, bub, stall};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        memread = 1'b0; idex_rt = '0; ifid_rs = '0; ifid_rt = '0;
        branch  = 1'b0; req = 1'b0; ack = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b0;
        tick(); tick();
        branch = 1'b1; req = 1'b1;
        #2;
        n_checks++;
        if (outs !== O_RST) $display("FAIL reset_outs: got %b expected %b", outs, O_RST);
        else n_pass++;
        n_checks++;
        if (mem_err !== 1'b0) $display("FAIL reset_err: got %b expected 0", mem_err);
        else n_pass++;
        tick();
        rst = 1'b1;
        idle();
        #2;
        n_checks++;
        if (outs !== O_RUN) $display("FAIL reset_release: got %b expected %b", outs, O_RUN);
        else n_pass++;
        tick();
    endtask

    task automatic test_load_use();
        idle();
        memread = 1'b1; idex_rt = 5'd5; ifid_rs = 5'd5; ifid_rt = 5'd7;
        #2;
        n_checks++;
        if (outs !== O_BUB) $display("FAIL lu_rs: got %b expected %b", outs, O_BUB);
        else n_pass++;
        tick();
        memread = 1'b0;
        #2;
        n_checks++;
        if (outs !== O_RUN) $display("FAIL lu_after: got %b expected %b", outs, O_RUN);
        else n_pass++;
        tick();
        memread = 1'b1; idex_rt = 5'd0; ifid_rs = 5'd0; ifid_rt = 5'd0;
        #2;
        n_checks++;
        if (outs !== O_RUN) $display("FAIL lu_r0: got %b expected %b", outs, O_RUN);
        else n_pass++;
        tick();
        idex_rt = 5'd9; ifid_rs = 5'd3; ifid_rt = 5'd9;
        #2;
        n_checks++;
        if (outs !== O_BUB) $display("FAIL lu_rt: got %b expected %b", outs, O_BUB);
        else n_pass++;
        tick();
        idle();
        tick();
    endtask

    task automatic test_branch();
        idle();
        branch = 1'b1;
        #2;
        n_checks++;
        if (outs !== O_FLU) $display("FAIL br_cycle1: got %b expected %b", outs, O_FLU);
        else n_pass++;
        tick();
        branch = 1'b1;   // wrong-path branch, must be ignored
        #2;
        n_checks++;
        if (outs !== O_FLU) $display("FAIL br_cycle2: got %b expected %b", outs, O_FLU);
        else n_pass++;
        tick();
        branch = 1'b0;
        #2;
        n_checks++;
        if (outs !== O_RUN) $display("FAIL br_done: got %b expected %b", outs, O_RUN);
        else n_pass++;
        tick();
    endtask

    task automatic test_mem_wait();
        idle();
        req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #2;
            n_checks++;
            if (outs !== O_FRZ) $display("FAIL mw_stall%0d: got %b expected %b", i, outs, O_FRZ);
            else n_pass++;
            tick();
        end
        ack = 1'b1;
        #2;
        n_checks++;
        if (outs !== O_RUN) $display("FAIL mw_ack: got %b expected %b", outs, O_RUN);
        else n_pass++;
        n_checks++;
        if (mem_err !== 1'b0) $display("FAIL mw_err: got %b expected 0", mem_err);
        else n_pass++;
        tick();
        idle();
        tick();
    endtask

    task automatic test_timeout();
        idle();
        req = 1'b1;
        for (int i = 1; i < int'(MT); i++) begin
            #2;
            n_checks++;
            if (outs !== O_FRZ || mem_err !== 1'b0)
                $display("FAIL to_cycle%0d: got %b err %b expected %b err 0", i, outs, mem_err, O_FRZ);
            else n_pass++;
            tick();
        end
        #2;
        n_checks++;
        if (outs !== O_RUN || mem_err !== 1'b1)
            $display("FAIL to_abort: got %b err %b expected %b err 1", outs, mem_err, O_RUN);
        else n_pass++;
        tick();
        idle();
        for (int i = 0; i < 3; i++) begin
            #2;
            n_checks++;
            if (outs !== O_RUN || mem_err !== 1'b1)
                $display("FAIL to_sticky%0d: got %b err %b expected %b err 1", i, outs, mem_err, O_RUN);
            else n_pass++;
            tick();
        end
    endtask

    task automatic test_simultaneous();
        idle();
        req = 1'b1; memread = 1'b1; idex_rt = 5'd4; ifid_rs = 5'd4; branch = 1'b1;
        #2;
        n_checks++;
        if (outs !== O_FRZ) $display("FAIL sim_freeze: got %b expected %b", outs, O_FRZ);
        else n_pass++;
        tick();
        ack = 1'b1;
        #2;
        n_checks++;
        if (outs !== O_BUB) $display("FAIL sim_bubble: got %b expected %b", outs, O_BUB);
        else n_pass++;
        tick();
        req = 1'b0; ack = 1'b0; memread = 1'b0;
        #2;
        n_checks++;
        if (outs !== O_FLU) $display("FAIL sim_flush1: got %b expected %b", outs, O_FLU);
        else n_pass++;
        tick();
        branch = 1'b0;
        #2;
        n_checks++;
        if (outs !== O_FLU) $display("FAIL sim_flush2: got %b expected %b", outs, O_FLU);
        else n_pass++;
        tick();
        #2;
        n_checks++;
        if (outs !== O_RUN) $display("FAIL sim_run: got %b expected %b", outs, O_RUN);
        else n_pass++;
        tick();
    endtask

    task automatic test_reset_mid_wait();
        idle();
        req = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        rst = 1'b0;
        #2;
        n_checks++;
        if (outs !== O_RST || mem_err !== 1'b0)
            $display("FAIL rmw_inreset: got %b err %b expected %b err 0", outs, mem_err, O_RST);
        else n_pass++;
        tick();
        rst = 1'b1;
        idle();
        #2;
        // A leftover MEM_WAIT would freeze here since ack is low.
        n_checks++;
        if (outs !== O_RUN || mem_err !== 1'b0)
            $display("FAIL rmw_after: got %b err %b expected %b err 0", outs, mem_err, O_RUN);
        else n_pass++;
`ifdef STALL_PERF_CNT_EN
        n_checks++;
        if (stall_cycles !== 32'd0 || flush_cycles !== 32'd0)
            $display("FAIL rmw_counters: got %0d/%0d expected 0/0", stall_cycles, flush_cycles);
        else n_pass++;
`endif
        tick();
    endtask

    task automatic test_random();
        int unsigned m_wait, m_left;
        bit          m_err, lu, waiting, hold, tmo, e_err;
        logic [4:0]  e;
        rst = 1'b0;
        idle();
        tick();
        m_wait = 0; m_left = 0; m_err = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            rst     = ($urandom_range(0, 199) != 0);
            memread = 1'($urandom_range(0, 1));
            idex_rt = 5'($urandom_range(0, 3));
            ifid_rs = 5'($urandom_range(0, 3));
            ifid_rt = 5'($urandom_range(0, 3));
            branch  = ($urandom_range(0, 3) == 0);
            req     = ($urandom_range(0, 2) != 0);
            ack     = ($urandom_range(0, 7) == 0);
            #2;
            lu      = memread && idex_rt != 0 && (idex_rt == ifid_rs || idex_rt == ifid_rt);
            waiting = (m_left == 0) && (m_wait > 0);
            hold    = waiting ? !ack : (req && !ack);
            tmo     = hold && (m_wait + 1 >= MT);
            if (!rst) begin
                e = O_RST; e_err = 1'b0;
                m_wait = 0; m_left = 0; m_err = 1'b0;
            end else if (hold && !tmo) begin
                e = O_FRZ; e_err = m_err;
                m_wait++;
            end else begin
                e_err  = m_err || tmo;
                m_err  = e_err;
                m_wait = 0;
                if (m_left > 0) begin
                    e = O_FLU; m_left--;
                end else if (lu) begin
                    e = O_BUB;
                end else if (branch) begin
                    e = O_FLU; m_left = FD - 1;
                end else begin
                    e = O_RUN;
                end
            end
            n_checks++;
            if (outs !== e) $display("FAIL rnd_outs cycle %0d: got %b expected %b", i, outs, e);
            else n_pass++;
            n_checks++;
            if (mem_err !== e_err) $display("FAIL rnd_err cycle %0d: got %b expected %b", i, mem_err, e_err);
            else n_pass++;
            tick();
        end
        rst = 1'b1;
    endtask

    initial begin
        idle();
        test_reset();
        test_load_use();
        test_branch();
        test_mem_wait();
        test_timeout();
        test_simultaneous();
        test_reset_mid_wait();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pipeline_stall_ctrl.md
# pipeline_stall_ctrl

Central stall/flush sequencer for the 5-stage MIPS pipeline. It merges three sources of pipeline disturbance into one prioritised set of register-enable and bubble controls for PC, IF/ID, ID/EX and EX/MEM:
- load-use hazards;
- taken branches/jumps;
- multi-cycle data-memory accesses.

It owns the memory-wait state machine, including its timeout watchdog, and the wrong-path flush sequencing.

## Interface
Parameters:
- FLUSH_DEPTH, 1: consecutive IF/ID flush cycles per taken branch/jump (legal 1..3).
- MEM_TIMEOUT, 16: max cycles spent in MEM_WAIT before abort (legal 2..255).

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  synchronous, active-low reset.
- IDEX_MemRead_i  in  1  ID/EX holds a load.
- IDEX_RegisterRt_i  in  5  load destination register.
- IFID_RegisterRs_i  in  5  rs of instruction in ID.
- IFID_RegisterRt_i  in  5  rt of instruction in ID.
- Branch_i  in  1  taken branch or jump resolved this cycle.
- mem_req_i  in  1  EX/MEM holds a data-memory access.
- mem_ack_i  in  1  data memory completes the access this cycle.
- PCWrite_o  out  1  PC load enable.
- IFIDWrite_o  out  1  IF/ID load enable.
- IFIDFlush_o  out  1  IF/ID cleared to NOP on this edge.
- IDEXBubble_o  out  1  ID/EX loads control-zero bubble.
- EXMEMStall_o  out  1  hold EX/MEM and MEM/WB (MEM/WB loads bubble).
- mem_err_o  out  1  sticky memory-timeout flag.

## Operation
- Load-use hazard:
  - `load_use = IDEX_MemRead_i && IDEX_RegisterRt_i != 0 && (IDEX_RegisterRt_i == IFID_RegisterRs_i || IDEX_RegisterRt_i == IFID_RegisterRt_i)`.
- Memory miss:
  - `miss = mem_req_i && !mem_ack_i`.
- FSM states: RUN, MEM_WAIT, FLUSH.
- Priority, evaluated each cycle: memory freeze > load_use > branch flush > normal advance.
- Freeze (any state, on miss): `PCWrite_o=0`, `IFIDWrite_o=0`, `IDEXBubble_o=0`, `IFIDFlush_o=0`, `EXMEMStall_o=1`.
- RUN:
  - miss: freeze, go to MEM_WAIT, wait counter = 1.
  - load_use: `PCWrite_o=0`, `IFIDWrite_o=0`, `IDEXBubble_o=1`; Branch_i ignored this cycle. The branch re-evaluates next cycle with the same ID instruction.
  - Branch_i: `PCWrite_o=1`, `IFIDFlush_o=1`. If FLUSH_DEPTH > 1, go to FLUSH with remaining = FLUSH_DEPTH-1.
  - Otherwise: `PCWrite_o=1`, `IFIDWrite_o=1`, all other outputs 0.
- MEM_WAIT:
  - `!mem_ack_i`: freeze; wait counter +1.
  - `mem_ack_i`: no freeze this cycle (pipeline advances); RUN rules apply to the other inputs; next state RUN.
  - Counter reaches MEM_TIMEOUT without ack: set `mem_err_o=1`, release the freeze that cycle, return to RUN.
- FLUSH:
  - `IFIDFlush_o=1`, `PCWrite_o=1`; remaining decrements each advancing cycle.
  - Branch_i and load_use are ignored (wrong-path instructions).
  - miss freezes and holds remaining; no transition to MEM_WAIT is taken. The wait counter still runs in FLUSH and times out identically.
  - remaining reaches 0: go to RUN.
- Outputs are combinational from state, counters and inputs; all state is registered.

## Timing
- Reset (rst_i low at an edge):
  - state = RUN, counters = 0, `mem_err_o=0`.
  - While rst_i is low, outputs are forced to `PCWrite_o=0`, `IFIDWrite_o=0`, `IFIDFlush_o=1`, `IDEXBubble_o=1`, `EXMEMStall_o=0`.
- Latency:
  - Load-use: exactly one bubble cycle.
  - Branch: FLUSH_DEPTH flush cycles, excluding frozen cycles.
  - Memory: stall cycles = cycles until ack, at most MEM_TIMEOUT-1.
- Same-cycle ack (`mem_req_i` and `mem_ack_i` both high in RUN): zero stall.
- Reset asserted mid-MEM_WAIT or mid-FLUSH: abandon immediately; the next cycle after release is RUN.
- `mem_err_o` clears only on reset.

## Configuration
- STALL_PERF_CNT_EN defined: adds ports `stall_cycles_o` (out, 32) and `flush_cycles_o` (out, 32).
  - `stall_cycles_o` counts cycles with `PCWrite_o=0` and rst_i high.
  - `flush_cycles_o` counts cycles with `IFIDFlush_o=1` and rst_i high.
  - Both saturate at 32'hFFFFFFFF and reset to 0.
- Not defined: neither port exists; no counter logic.

## Test plan
- Load-use: `IDEX_MemRead_i=1`, Rt=5, `IFID_RegisterRs_i=5` -> one cycle with `PCWrite_o=0`, `IFIDWrite_o=0`, `IDEXBubble_o=1`, then normal advance. Repeat with Rt=0 -> no stall.
- Branch with FLUSH_DEPTH=2: `Branch_i=1` for one cycle -> `IFIDFlush_o=1` for 2 consecutive cycles, `PCWrite_o=1` throughout; a `Branch_i` pulse in the second cycle is ignored.
- Memory wait: `mem_req_i=1`, ack after 4 cycles -> `EXMEMStall_o=1` for 4 cycles, 0 on the ack cycle, `mem_err_o` stays 0.
- Timeout with MEM_TIMEOUT=16: `mem_req_i=1`, never acked -> `mem_err_o` rises in cycle 16, freeze released, flag sticky until reset.
- Simultaneous events:
  - miss + load_use + Branch_i -> freeze only.
  - After ack, load_use bubble.
  - Then branch flush, in that order.
- Reset mid-MEM_WAIT: rst_i low for 1 cycle at wait count 3 -> reset output values; RUN afterwards; with STALL_PERF_CNT_EN, counters read 0.
